// File: rtl/iob_cache_be_arbiter_pkg.sv
// Shared definitions for the back-end arbiter slice.
//   arb_state_t : arbiter FSM encoding (IDLE = 0, LOCKED = 1)
//   calc_id_w   : width of a manager ID for a given manager count
package iob_cache_be_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int calc_id_w(input int n_managers);
        return $clog2(n_managers);
    endfunction

endpackage

// File: rtl/iob_cache_arb_id_fifo.sv
// In-order FIFO of manager IDs for reads that are still waiting for rvalid.
//   clk_i, cke_i, arst_i : clock, clock enable, synchronous active-high reset
//   push_i, push_data_i  : write one ID (ignored when full)
//   pop_i                : drop the head entry (ignored when empty)
//   head_o               : ID at the head, combinational
//   full_o, empty_o      : occupancy flags, reflect state before this cycle's push/pop
module iob_cache_arb_id_fifo
#(
    parameter int W       = 1,
    parameter int DEPTH_W = 2
)(
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int DEPTH = 2 ** DEPTH_W;

    logic [W-1:0]       mem_reg [DEPTH];
    logic [DEPTH_W-1:0] wr_ptr_reg;
    logic [DEPTH_W-1:0] rd_ptr_reg;
    logic [DEPTH_W:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_reg == (DEPTH_W + 1)'(DEPTH));
    assign empty_o = (count_reg == '0);
    assign head_o  = mem_reg[rd_ptr_reg];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Storage carries no reset: entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (cke_i && do_push) begin
            mem_reg[wr_ptr_reg] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (cke_i) begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/iob_cache_be_arbiter.sv
// Round-robin arbiter sharing one back-end IOb subordinate among N managers.
// Requests and responses pass through combinationally; an ID FIFO remembers
// which manager issued each outstanding read so rvalid can be routed back.
//   clk_i, cke_i, arst_i            : clock, clock enable, sync active-high reset
//   m_iob_valid/addr/wdata/wstrb_i  : concatenated manager requests (manager 0 in LSBs)
//   m_iob_ready_o, m_iob_rvalid_o   : per-manager accept / read-data valid
//   m_iob_rdata_o                   : back-end read data broadcast to every slice
//   s_iob_*                         : back-end request and response
//   err_o                           : sticky, rvalid seen with no read outstanding
module iob_cache_be_arbiter
    import iob_cache_be_arbiter_pkg::*;
#(
    parameter int N_MANAGERS   = 2,
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int RESP_DEPTH_W = 2,
    parameter int ID_W         = calc_id_w(N_MANAGERS)
)(
    input  logic                           clk_i,
    input  logic                           cke_i,
    input  logic                           arst_i,
    input  logic [N_MANAGERS-1:0]          m_iob_valid_i,
    input  logic [N_MANAGERS*ADDR_W-1:0]   m_iob_addr_i,
    input  logic [N_MANAGERS*DATA_W-1:0]   m_iob_wdata_i,
    input  logic [N_MANAGERS*DATA_W/8-1:0] m_iob_wstrb_i,
    output logic [N_MANAGERS-1:0]          m_iob_ready_o,
    output logic [N_MANAGERS-1:0]          m_iob_rvalid_o,
    output logic [N_MANAGERS*DATA_W-1:0]   m_iob_rdata_o,
    output logic                           s_iob_valid_o,
    output logic [ADDR_W-1:0]              s_iob_addr_o,
    output logic [DATA_W-1:0]              s_iob_wdata_o,
    output logic [DATA_W/8-1:0]            s_iob_wstrb_o,
    input  logic                           s_iob_ready_i,
    input  logic                           s_iob_rvalid_i,
    input  logic [DATA_W-1:0]              s_iob_rdata_i,
    output logic                           err_o
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t      state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] grant_id_reg;
    logic            err_reg;

    logic [ADDR_W-1:0] req_addr  [N_MANAGERS];
    logic [DATA_W-1:0] req_wdata [N_MANAGERS];
    logic [STRB_W-1:0] req_wstrb [N_MANAGERS];

    logic            rr_found;
    logic [ID_W-1:0] rr_grant;
    logic [ID_W-1:0] grant_id;
    logic            grant_valid;
    logic [ID_W-1:0] rr_ptr_next;
    logic            is_read;
    logic            read_blocked;
    logic            accept;

    logic            fifo_full;
    logic            fifo_empty;
    logic [ID_W-1:0] fifo_head;
    logic            fifo_push;
    logic            fifo_pop;

    for (genvar gi = 0; gi < N_MANAGERS; gi++) begin : g_slice
        assign req_addr[gi]  = m_iob_addr_i[gi*ADDR_W +: ADDR_W];
        assign req_wdata[gi] = m_iob_wdata_i[gi*DATA_W +: DATA_W];
        assign req_wstrb[gi] = m_iob_wstrb_i[gi*STRB_W +: STRB_W];

        assign m_iob_ready_o[gi]  = s_iob_ready_i & grant_valid
                                  & (grant_id == ID_W'(gi)) & ~read_blocked;
        assign m_iob_rvalid_o[gi] = fifo_pop & (fifo_head == ID_W'(gi));
        assign m_iob_rdata_o[gi*DATA_W +: DATA_W] = s_iob_rdata_i;
    end

    // First asserted valid at or above rr_ptr, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        for (int k = 0; k < N_MANAGERS; k++) begin
            int idx;
            idx = int'(rr_ptr_reg) + k;
            if (idx >= N_MANAGERS) idx = idx - N_MANAGERS;
            if (!rr_found && m_iob_valid_i[idx]) begin
                rr_found = 1'b1;
                rr_grant = ID_W'(idx);
            end
        end
    end

    // Once locked, the held grant ignores the round-robin search entirely.
    assign grant_id    = (state_reg == LOCKED) ? grant_id_reg : rr_grant;
    assign grant_valid = (state_reg == LOCKED) ? m_iob_valid_i[grant_id_reg] : rr_found;
    assign rr_ptr_next = (grant_id == ID_W'(N_MANAGERS - 1)) ? '0 : grant_id + 1'b1;

    assign is_read      = ~|req_wstrb[grant_id];
    assign read_blocked = grant_valid & is_read & fifo_full;

    assign s_iob_valid_o = grant_valid & ~read_blocked;
    assign s_iob_addr_o  = grant_valid ? req_addr[grant_id]  : '0;
    assign s_iob_wdata_o = grant_valid ? req_wdata[grant_id] : '0;
    assign s_iob_wstrb_o = grant_valid ? req_wstrb[grant_id] : '0;

    assign accept    = s_iob_valid_o & s_iob_ready_i;
    assign fifo_push = accept & is_read;
    assign fifo_pop  = s_iob_rvalid_i & ~fifo_empty;
    assign err_o     = err_reg;

    iob_cache_arb_id_fifo #(
        .W       (ID_W),
        .DEPTH_W (RESP_DEPTH_W)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .arst_i      (arst_i),
        .push_i      (fifo_push),
        .push_data_i (grant_id),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            err_reg      <= 1'b0;
        end else if (cke_i) begin
            if (s_iob_rvalid_i && fifo_empty) err_reg <= 1'b1;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        if (accept) begin
                            rr_ptr_reg <= rr_ptr_next;
                        end else begin
                            // Back-end busy or read blocked: hold this grant.
                            grant_id_reg <= grant_id;
                            state_reg    <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= rr_ptr_next;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
